// File: rtl/stopwatch_time_counter.sv
// Stopwatch timebase and six-digit BCD time counter (MM:SS.cc) with
// start/stop, clear and lap control; digit outputs feed 7-segment decoders.
module stopwatch_time_counter #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] cs_t,
  output logic [3:0] cs_o,
  output logic       running,
  output logic       frozen,
  output logic       wrap
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  // Digit order, index 0 first: cs_o, cs_t, sec_o, sec_t, min_o, min_t
  localparam logic [5:0][3:0] LIMIT = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [5:0][3:0]  live_q, live_d, live_inc;
  logic [5:0][3:0]  snap_q, snap_d;
  logic [5:0][3:0]  disp_q, disp_d;
  logic             run_q, run_d;
  logic             frz_q, frz_d;
  logic             wrap_q, wrap_d;
  logic             counting, tick, carry;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        LAP:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (lap) begin
      if (state_q == RUN)      state_d = LAP;
      else if (state_q == LAP) state_d = RUN;
    end
  end

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    if (clear || state_q == IDLE) pre_d = '0;
    else if (counting)            pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // Ripple the tick through the digits; a carry surviving the top digit is the rollover.
  always_comb begin
    carry    = tick;
    live_inc = live_q;
    for (int unsigned i = 0; i < 6; i++) begin
      if (carry) begin
        if (live_q[i] == LIMIT[i]) begin
          live_inc[i] = '0;
        end else begin
          live_inc[i] = live_q[i] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
  end

  // Display and flags are precomputed from next-state so the ports come straight off flops.
  always_comb begin
    live_d = clear ? '0 : live_inc;
    snap_d = snap_q;
    if (clear)                                     snap_d = '0;
    else if (state_q != LAP && state_d == LAP)     snap_d = live_q;
    disp_d = (state_d == LAP) ? snap_d : live_d;
    run_d  = (state_d == RUN) || (state_d == LAP);
    frz_d  = (state_d == LAP);
    wrap_d = carry && !clear;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      live_q  <= '0;
      snap_q  <= '0;
      disp_q  <= '0;
      run_q   <= 1'b0;
      frz_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      live_q  <= live_d;
      snap_q  <= snap_d;
      disp_q  <= disp_d;
      run_q   <= run_d;
      frz_q   <= frz_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cs_o    = disp_q[0];
  assign cs_t    = disp_q[1];
  assign sec_o   = disp_q[2];
  assign sec_t   = disp_q[3];
  assign min_o   = disp_q[4];
  assign min_t   = disp_q[5];
  assign running = run_q;
  assign frozen  = frz_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter at DIV=10 (1 kHz clock, 100 Hz tick).
module tb_stopwatch_time_counter;

  logic       clk;
  logic       rst_n;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] min_t, min_o, sec_t, sec_o, cs_t, cs_o;
  logic       running, frozen, wrap;

  int n_cmp;
  int n_err;

  stopwatch_time_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .min_t      (min_t),
    .min_o      (min_o),
    .sec_t      (sec_t),
    .sec_o      (sec_o),
    .cs_t       (cs_t),
    .cs_o       (cs_o),
    .running    (running),
    .frozen     (frozen),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] disp();
    return {min_t, min_o, sec_t, sec_o, cs_t, cs_o};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse helpers are entered at a negedge; the pulse is sampled by the following posedge.
  task automatic press_start();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic press_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic press_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    n_cmp++;
    if (disp() !== 24'h000000) begin n_err++; $display("FAIL reset_digits: got %h want %h", disp(), 24'h000000); end
    n_cmp++;
    if ({running, frozen, wrap} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want %b", {running, frozen, wrap}, 3'b000); end
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_start();
    press_start();
    n_cmp++;
    if (running !== 1'b1) begin n_err++; $display("FAIL start_running: got %b want %b", running, 1'b1); end
    wait_cyc(9);
    n_cmp++;
    if (disp() !== 24'h000000) begin n_err++; $display("FAIL start_before_tick: got %h want %h", disp(), 24'h000000); end
    wait_cyc(1);
    n_cmp++;
    if (disp() !== 24'h000001) begin n_err++; $display("FAIL start_first_tick: got %h want %h", disp(), 24'h000001); end
    wait_cyc(240);
    n_cmp++;
    if (disp() !== 24'h000025) begin n_err++; $display("FAIL start_250: got %h want %h", disp(), 24'h000025); end
    press_clear();
    n_cmp++;
    if ({disp(), running} !== {24'h000000, 1'b0}) begin n_err++; $display("FAIL clear_idle: got %h/%b want %h/%b", disp(), running, 24'h000000, 1'b0); end
  endtask

  task automatic test_carries();
    press_start();
    wait_cyc(990);
    n_cmp++;
    if (disp() !== 24'h000099) begin n_err++; $display("FAIL carry_99: got %h want %h", disp(), 24'h000099); end
    wait_cyc(10);
    n_cmp++;
    if (disp() !== 24'h000100) begin n_err++; $display("FAIL carry_100: got %h want %h", disp(), 24'h000100); end
    wait_cyc(58990);
    n_cmp++;
    if (disp() !== 24'h005999) begin n_err++; $display("FAIL carry_5999: got %h want %h", disp(), 24'h005999); end
    wait_cyc(10);
    n_cmp++;
    if (disp() !== 24'h010000) begin n_err++; $display("FAIL carry_min: got %h want %h", disp(), 24'h010000); end
    press_clear();
  endtask

  task automatic test_wrap();
    force dut.live_q = 24'h595998;
    @(negedge clk);
    release dut.live_q;
    n_cmp++;
    if (disp() !== 24'h595998) begin n_err++; $display("FAIL wrap_preload: got %h want %h", disp(), 24'h595998); end
    press_start();
    wait_cyc(10);
    n_cmp++;
    if ({disp(), wrap} !== {24'h595999, 1'b0}) begin n_err++; $display("FAIL wrap_max: got %h/%b want %h/%b", disp(), wrap, 24'h595999, 1'b0); end
    wait_cyc(10);
    n_cmp++;
    if ({disp(), wrap, running} !== {24'h000000, 1'b1, 1'b1}) begin n_err++; $display("FAIL wrap_roll: got %h/%b/%b want %h/1/1", disp(), wrap, running, 24'h000000); end
    wait_cyc(1);
    n_cmp++;
    if (wrap !== 1'b0) begin n_err++; $display("FAIL wrap_one_cycle: got %b want %b", wrap, 1'b0); end
    wait_cyc(9);
    n_cmp++;
    if (disp() !== 24'h000001) begin n_err++; $display("FAIL wrap_continue: got %h want %h", disp(), 24'h000001); end
    press_clear();
  endtask

  task automatic test_pause();
    press_start();
    // Pause pulse sampled on the 4th edge after start, leaving the prescaler at 4.
    wait_cyc(3);
    press_start();
    n_cmp++;
    if (running !== 1'b0) begin n_err++; $display("FAIL pause_running: got %b want %b", running, 1'b0); end
    wait_cyc(100);
    n_cmp++;
    if (disp() !== 24'h000000) begin n_err++; $display("FAIL pause_hold: got %h want %h", disp(), 24'h000000); end
    press_start();
    wait_cyc(5);
    n_cmp++;
    if (disp() !== 24'h000000) begin n_err++; $display("FAIL resume_early: got %h want %h", disp(), 24'h000000); end
    wait_cyc(1);
    n_cmp++;
    if (disp() !== 24'h000001) begin n_err++; $display("FAIL resume_tick6: got %h want %h", disp(), 24'h000001); end
    press_clear();
  endtask

  task automatic test_lap();
    press_start();
    wait_cyc(1230);
    n_cmp++;
    if (disp() !== 24'h000123) begin n_err++; $display("FAIL lap_pre: got %h want %h", disp(), 24'h000123); end
    press_lap();
    n_cmp++;
    if ({disp(), frozen, running} !== {24'h000123, 1'b1, 1'b1}) begin n_err++; $display("FAIL lap_enter: got %h/%b/%b want %h/1/1", disp(), frozen, running, 24'h000123); end
    wait_cyc(500);
    n_cmp++;
    if ({disp(), frozen} !== {24'h000123, 1'b1}) begin n_err++; $display("FAIL lap_hold: got %h/%b want %h/1", disp(), frozen, 24'h000123); end
    press_lap();
    n_cmp++;
    if ({disp(), frozen, running} !== {24'h000173, 1'b0, 1'b1}) begin n_err++; $display("FAIL lap_release: got %h/%b/%b want %h/0/1", disp(), frozen, running, 24'h000173); end
    press_clear();
  endtask

  task automatic test_clear_start();
    press_start();
    wait_cyc(9);
    // clear and start_stop together on the tick edge: clear wins and the tick is dropped
    clear      = 1'b1;
    start_stop = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
    start_stop = 1'b0;
    n_cmp++;
    if ({disp(), running, frozen, wrap} !== {24'h000000, 3'b000}) begin n_err++; $display("FAIL clear_start: got %h/%b want %h/000", disp(), {running, frozen, wrap}, 24'h000000); end
    wait_cyc(20);
    n_cmp++;
    if ({disp(), running} !== {24'h000000, 1'b0}) begin n_err++; $display("FAIL clear_stays_idle: got %h/%b want %h/0", disp(), running, 24'h000000); end
  endtask

  task automatic test_async_reset();
    press_start();
    wait_cyc(250);
    n_cmp++;
    if (disp() !== 24'h000025) begin n_err++; $display("FAIL areset_pre: got %h want %h", disp(), 24'h000025); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({disp(), running, frozen, wrap} !== {24'h000000, 3'b000}) begin n_err++; $display("FAIL areset_immediate: got %h/%b want %h/000", disp(), {running, frozen, wrap}, 24'h000000); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(20);
    n_cmp++;
    if ({disp(), running} !== {24'h000000, 1'b0}) begin n_err++; $display("FAIL areset_idle: got %h/%b want %h/0", disp(), running, 24'h000000); end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    @(negedge clk);
    test_reset();
    test_start();
    test_carries();
    test_wrap();
    test_pause();
    test_lap();
    test_clear_start();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
